// File: rtl/rom_stream_reader.sv
// Walks a ROM from address 0 and streams every byte before the first sentinel on a
// valid/ready port, keeping a running count and sum of the accepted bytes.
module rom_stream_reader #(
    parameter int unsigned       ADDR_W   = 9,
    parameter int unsigned       DATA_W   = 8,
    parameter logic [DATA_W-1:0] SENTINEL = 8'hFF
) (
    input  logic                     control,
    input  logic                     reset,
    input  logic                     start,
    output logic [ADDR_W-1:0]        rom_addr,
    output logic                     rom_readEn,
    input  logic [DATA_W-1:0]        rom_data,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W:0]          count,
    output logic [DATA_W+ADDR_W-1:0] sum
);

    localparam int unsigned CountW = ADDR_W + 1;
    localparam int unsigned SumW   = DATA_W + ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StHold,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CountW-1:0] count_q, count_d;
    logic [SumW-1:0]   sum_q, sum_d;

    logic accept;
    logic last_addr;
    logic is_sentinel;

    assign accept      = (state_q == StHold) && out_ready;
    assign last_addr   = (addr_q == {ADDR_W{1'b1}});
    assign is_sentinel = (rom_data == SENTINEL);

    // State register
    always_ff @(posedge control) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                state_d = StWait;
            end
            StWait: begin
                state_d = is_sentinel ? StDone : StHold;
            end
            StHold: begin
                // The top address ends the walk so rom_addr never wraps back to 0.
                if (out_ready) begin
                    state_d = last_addr ? StDone : StReq;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode
    always_comb begin
        rom_readEn = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            StIdle:  busy       = 1'b0;
            StReq:   rom_readEn = 1'b1;
            StWait:  ;
            StHold:  out_valid  = 1'b1;
            StDone:  done       = 1'b1;
            default: busy       = 1'b0;
        endcase
    end

    // Datapath next-state
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        sum_d   = sum_q;
        if ((state_q == StIdle) && start) begin
            addr_d  = '0;
            count_d = '0;
            sum_d   = '0;
        end
        if ((state_q == StWait) && !is_sentinel) begin
            data_d = rom_data;
        end
        if (accept) begin
            count_d = count_q + CountW'(1);
            sum_d   = sum_q + SumW'(data_q);
            if (!last_addr) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge control) begin
        if (reset) begin
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            sum_q   <= sum_d;
        end
    end

    assign rom_addr = addr_q;
    assign out_data = data_q;
    assign count    = count_q;
    assign sum      = sum_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: a ROM model plus a transaction-level reference that derives
// per-cycle expectations from the element timing rules, under directed and random traffic.
module tb_rom_stream_reader;

    localparam int         Depth = 512;
    localparam logic [7:0] Sent  = 8'hFF;

    logic        control   = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  rom_data  = 8'h00;
    logic [8:0]  rom_addr;
    logic        rom_readEn;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic [9:0]  count;
    logic [16:0] sum;

    rom_stream_reader #(
        .ADDR_W  (9),
        .DATA_W  (8),
        .SENTINEL(8'hFF)
    ) dut (
        .control   (control),
        .reset     (reset),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_readEn(rom_readEn),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .sum       (sum)
    );

    always #5 control = ~control;

    // Registered ROM: output updates at the edge that samples rom_readEn high.
    logic [7:0] rom [Depth];
    always @(posedge control) begin
        if (rom_readEn) rom_data <= rom[rom_addr];
    end

    // Reference state: expected stream and where the walk stands.
    logic [7:0] exp_q[$];
    int  n_exp, acc, exp_sum, t_v, done_cyc, done_at, cyc;
    int  ready_mode = 0;
    bit  in_walk = 0, skip_first = 0, valid_seen = 0, start_req = 0, spam = 0;
    int  n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic ready_for(input int c);
        case (ready_mode)
            0:       return 1'b1;
            1:       return $urandom_range(0, 3) != 0;
            2:       return !(c >= 6 && c <= 10);
            default: return 1'b0;
        endcase
    endfunction

    // Input driver: values for walk cycle cyc+1, applied just after the edge that opens it.
    initial forever begin
        @(posedge control);
        #1;
        out_ready = ready_for(cyc + 1);
        start = start_req || (spam && in_walk && !skip_first && (cyc + 1 <= done_cyc)
                              && $urandom_range(0, 1) == 1);
    end

    // Compare process: element k is valid from t_v (3 cycles after the previous acceptance),
    // its read is issued at t_v-2, and the walk ends per the sentinel/top-address rules.
    initial begin
        bit ev, er;
        forever begin
            @(negedge control);
            if (in_walk) begin
                if (skip_first) begin
                    skip_first = 0;
                    check("busy_before_start", 32'(busy), 32'(0));
                end else begin
                    cyc++;
                    ev = (acc < n_exp) && (cyc >= t_v);
                    er = (cyc == t_v - 2) && (acc < Depth);
                    check("out_valid", 32'(out_valid), 32'(ev));
                    if (ev) check("out_data", 32'(out_data), 32'(exp_q[acc]));
                    check("rom_readEn", 32'(rom_readEn), 32'(er));
                    check("rom_addr", 32'(rom_addr), (acc > Depth - 1) ? Depth - 1 : acc);
                    check("done", 32'(done), 32'(cyc == done_cyc));
                    check("busy", 32'(busy), 32'(cyc <= done_cyc));
                    check("count", 32'(count), acc);
                    check("sum", 32'(sum), exp_sum);
                    if (out_valid) valid_seen = 1;
                    if (done) done_at = cyc;
                    if (ev && out_ready) begin
                        exp_sum += int'(exp_q[acc]);
                        acc++;
                        t_v = cyc + 3;
                        if (acc == n_exp) done_cyc = (n_exp == Depth) ? cyc + 1 : cyc + 3;
                    end
                    if (cyc > done_cyc) in_walk = 0;
                end
            end
        end
    end

    task automatic begin_walk(input int mode, input bit do_spam);
        ready_mode = mode;
        spam       = do_spam;
        exp_q.delete();
        for (int a = 0; a < Depth; a++) begin
            if (rom[a] == Sent) break;
            exp_q.push_back(rom[a]);
        end
        n_exp      = exp_q.size();
        acc        = 0;
        exp_sum    = 0;
        t_v        = 3;
        done_cyc   = (n_exp == 0) ? 3 : 1000000;
        done_at    = -1;
        valid_seen = 0;
        @(negedge control);
        #2;
        cyc        = 0;
        skip_first = 1;
        start_req  = 1;
        in_walk    = 1;
        @(negedge control);
        #2;
        start_req = 0;
    endtask

    task automatic finish_walk();
        for (int i = 0; i < 6000 && in_walk; i++) @(negedge control);
        #2;
        if (in_walk) begin
            n_checks++;
            n_fail++;
            $display("FAIL walk_timeout: walk still running after 6000 cycles");
            in_walk = 0;
        end
    endtask

    task automatic fill_t1();
        for (int a = 0; a < Depth; a++) rom[a] = 8'($urandom_range(0, 255));
        rom[0] = 8'd27;
        rom[1] = 8'd5;
        rom[2] = 8'd33;
        rom[3] = 8'd3;
        rom[4] = Sent;
    endtask

    task automatic fill_random(input int sent_pos);
        for (int a = 0; a < Depth; a++) rom[a] = 8'($urandom_range(0, 254));
        if (sent_pos < Depth) rom[sent_pos] = Sent;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge control);
        @(negedge control);
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_readEn", 32'(rom_readEn), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(count), 0);
        check("rst_sum", 32'(sum), 0);
        #2;
        reset = 0;

        // Basic table, no stalls
        fill_t1();
        begin_walk(0, 0);
        finish_walk();
        check("t1_done_cycle", done_at, 15);
        check("t1_count", 32'(count), 4);
        check("t1_sum", 32'(sum), 68);
        repeat (3) @(negedge control);
        check("t1_count_hold", 32'(count), 4);
        check("t1_sum_hold", 32'(sum), 68);
        check("t1_busy_idle", 32'(busy), 0);

        // Five stall cycles while byte 5 is presented
        begin_walk(2, 0);
        finish_walk();
        check("t2_done_cycle", done_at, 20);
        check("t2_count", 32'(count), 4);
        check("t2_sum", 32'(sum), 68);

        // Empty table
        fill_random(0);
        begin_walk(0, 0);
        finish_walk();
        check("t3_done_cycle", done_at, 3);
        check("t3_valid_seen", 32'(valid_seen), 0);
        check("t3_count", 32'(count), 0);
        check("t3_sum", 32'(sum), 0);

        // Full table of ones, no sentinel
        for (int a = 0; a < Depth; a++) rom[a] = 8'h01;
        begin_walk(0, 0);
        finish_walk();
        check("t4_done_cycle", done_at, 1537);
        check("t4_count", 32'(count), 512);
        check("t4_sum", 32'(sum), 512);

        // Reset while holding a byte, then a clean restart
        fill_t1();
        begin_walk(3, 0);
        for (int i = 0; i < 20 && cyc < 5; i++) @(negedge control);
        #2;
        check("t5_valid_before_reset", 32'(out_valid), 1);
        in_walk = 0;
        reset   = 1;
        @(negedge control);
        #2;
        check("t5_rst_addr", 32'(rom_addr), 0);
        check("t5_rst_readEn", 32'(rom_readEn), 0);
        check("t5_rst_out_data", 32'(out_data), 0);
        check("t5_rst_out_valid", 32'(out_valid), 0);
        check("t5_rst_done", 32'(done), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_count", 32'(count), 0);
        check("t5_rst_sum", 32'(sum), 0);
        reset = 0;
        begin_walk(0, 0);
        finish_walk();
        check("t5_done_cycle", done_at, 15);
        check("t5_count", 32'(count), 4);
        check("t5_sum", 32'(sum), 68);

        // start toggled while busy must not disturb the walk
        begin_walk(0, 1);
        finish_walk();
        check("t6_done_cycle", done_at, 15);
        check("t6_count", 32'(count), 4);
        check("t6_sum", 32'(sum), 68);
        spam = 0;

        // Random tables and random backpressure
        for (int w = 0; w < 5; w++) begin
            fill_random((w == 4) ? Depth : int'($urandom_range(0, 40)));
            begin_walk(1, 0);
            finish_walk();
            check("rnd_count", 32'(count), n_exp);
            check("rnd_sum", 32'(sum), exp_sum);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
